// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_fullsub.sv
// Single-bit combinational full subtractor: diff = a - b - b_in, borrow out in b_out.
module fullsub (
    output logic diff,
    output logic b_out,
    input  logic a,
    input  logic b,
    input  logic b_in
);

    always_comb begin
        diff  = a ^ b ^ b_in;
        b_out = (~a & b) | (~(a ^ b) & b_in);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one bit per RUN cycle; result is registered on the last bit.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-2:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    fullsub u_cell (
        .diff (d_bit),
        .b_out(br_next),
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .b_in (br)
    );

    // The final result is the new bit on top of the WIDTH-1 bits already collected.
    assign res_next = {d_bit, res};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            diff  <= '0;
            b_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sh_a <= a;
                        sh_b <= b;
                        br   <= b_in;
                        res  <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    sh_a <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b <= {1'b0, sh_b[WIDTH-1:1]};
                    res  <= res_next[WIDTH-1:1];
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        diff  <= res_next;
                        b_out <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the shift-register LSBs are the operand sign bits.
                        ovf   <= (sh_a[0] != sh_b[0]) && (d_bit != sh_a[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: driver pushes arithmetic expectations, monitor checks on done.
module tb_serial_sub;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         b_out;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         b_in = 1'b0;
    logic         ready;
    logic [W-1:0] diff;
    logic         b_out;
    logic         done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = -1;
    exp_t sb[$];

    serial_sub #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .b_in (b_in),
        .ready(ready),
        .diff (diff),
        .b_out(b_out),
        .done (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input int unsigned av, input int unsigned bv, input int unsigned bi);
        exp_t e;
        int   t;
        t         = int'(av) - int'(bv) - int'(bi);
        e.diff    = W'((t + 1024) % (1 << W));
        e.b_out   = (av < bv + bi);
        e.ovf     = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", int'(diff), int'(e.diff));
                chk("b_out", int'(b_out), int'(e.b_out));
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", int'(ovf), int'(e.ovf));
`endif
                // done appears WIDTH edges after the accepting edge (WIDTH+1 cycles counting the accept cycle)
                chk("latency", cyc - e.acc_cyc, W);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic accept_edge(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        @(posedge clk);
        #1;
        e         = model(av, bv, bi);
        e.acc_cyc = cyc;
        sb.push_back(e);
        last_acc  = cyc;
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        wait_ready();
        chk("ready_idle", int'(ready), 1);
        a = av; b = bv; b_in = bi; start = 1'b1;
        accept_edge(av, bv, bi);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_b_out", int'(b_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(8'h05, 8'h03, 1'b0); drain();
        do_op(8'h03, 8'h05, 1'b0); drain();
        do_op(8'h00, 8'h00, 1'b1); drain();
        do_op(8'hFF, 8'hFF, 1'b1); drain();
        do_op(8'h80, 8'h01, 1'b0); drain();
        do_op(8'h10, 8'h01, 1'b0); drain();
        do_op(8'h7F, 8'hFF, 1'b0); drain();

        // Start pulsed mid-RUN with other operands must be ignored.
        do_op(8'h5A, 8'h21, 1'b1);
        repeat (2) @(negedge clk);
        chk("ready_run", int'(ready), 0);
        a = 8'hEE; b = 8'h11; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("no_queue", sb.size(), 0);

        // Start held high: back-to-back accepts every WIDTH+2 cycles.
        begin
            int prev;
            wait_ready();
            start = 1'b1;
            prev  = -1;
            for (int k = 0; k < 3; k++) begin
                logic [W-1:0] av, bv;
                logic         bi;
                if (k != 0) wait_ready();
                av = W'($urandom); bv = W'($urandom); bi = 1'($urandom);
                a = av; b = bv; b_in = bi;
                accept_edge(av, bv, bi);
                if (prev >= 0) chk("b2b_period", last_acc - prev, W + 2);
                prev = last_acc;
            end
            @(negedge clk);
            start = 1'b0;
            drain();
        end

        // Reset at RUN cycle 4 aborts the operation.
        do_op(8'hC3, 8'h3C, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_b_out", int'(b_out), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * W) @(negedge clk);
        do_op(8'h05, 8'h03, 1'b0); drain();

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
